// File: rtl/tone_pkg.sv
// Shared widths, note table and FSM states for the tone player.
package tone_pkg;

   localparam int NOTE_BITS   = 4;
   localparam int OCTAVE_BITS = 2;
   localparam int LENGTH_BITS = 3;
   localparam int HP_BITS     = 20;

   typedef enum logic [1:0] {
      IDLE,
      PLAY,
      GAP,
      DONE
   } state_t;

   // Index 0 is the rest slot; 1..7 are mid-octave C..B half periods.
   localparam logic [HP_BITS-1:0] MID_HALF [8] = '{
      20'd0,
      20'd191110,
      20'd170265,
      20'd151685,
      20'd143172,
      20'd127551,
      20'd113636,
      20'd101239
   };

   function automatic logic is_tone(input logic [NOTE_BITS-1:0] n);
      return !n[3] && (n[2:0] != 3'd0);
   endfunction

   function automatic logic [HP_BITS-1:0] note_half_period(
      input logic [OCTAVE_BITS-1:0] oct,
      input logic [NOTE_BITS-1:0]   n
   );
      logic [HP_BITS-1:0] base;
      base = MID_HALF[n[2:0]];
      case (oct)
         2'd0:    return base << 1;
         2'd2:    return base >> 1;
         default: return base;
      endcase
   endfunction

endpackage

// File: rtl/tone_divider.sv
// Square-wave generator: output starts low and toggles every half_period cycles.
module tone_divider
   import tone_pkg::*;
#(
   parameter int W = HP_BITS
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         enable,
   input  logic [W-1:0] half_period,
   output logic         wave
);

   logic [W-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt  <= '0;
         wave <= 1'b0;
      end else if (!enable) begin
         cnt  <= '0;
         wave <= 1'b0;
      end else if (cnt == half_period - W'(1)) begin
         cnt  <= '0;
         wave <= ~wave;
      end else begin
         cnt <= cnt + W'(1);
      end
   end

endmodule

// File: rtl/tone_player.sv
// Single-note player: latches a note on start, plays it for a coded length.
// Define TONE_GAP_EN to append a silent articulation gap after each note.
module tone_player
   import tone_pkg::*;
#(
   parameter int SIXTEENTH_CYCLES = 12_500_000,
   parameter int GAP_CYCLES       = 1_000_000
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic                   stop,
   input  logic [OCTAVE_BITS-1:0] octave,
   input  logic [NOTE_BITS-1:0]   note,
   input  logic [LENGTH_BITS-1:0] length,
   output logic                   busy,
   output logic                   done,
   output logic                   buzzer
);

   localparam int MAX_DUR = (16 * SIXTEENTH_CYCLES > GAP_CYCLES) ?
                            16 * SIXTEENTH_CYCLES : GAP_CYCLES;
   localparam int CNT_W   = $clog2(MAX_DUR + 1);
   localparam int DIV_W   = (CNT_W > HP_BITS) ? CNT_W : HP_BITS;

   state_t state, state_next;

   logic [OCTAVE_BITS-1:0] oct_q;
   logic [NOTE_BITS-1:0]   note_q;
   logic [LENGTH_BITS-1:0] len_q;
   logic [CNT_W-1:0]       dur;
   logic [CNT_W-1:0]       play_last;
   logic [2:0]             shift;
   logic                   tone_en;
   logic                   accept;

   // Length codes 5..7 clamp to a whole note.
   assign shift     = len_q[2] ? 3'd4 : len_q;
   assign play_last = (CNT_W'(SIXTEENTH_CYCLES) << shift) - CNT_W'(1);
   assign accept    = (state == IDLE) && start && !stop;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      unique case (state)
         IDLE: begin
            if (accept) state_next = PLAY;
         end
         PLAY: begin
            if (stop) state_next = IDLE;
`ifdef TONE_GAP_EN
            else if (dur == play_last) state_next = GAP;
`else
            else if (dur == play_last) state_next = DONE;
`endif
         end
         GAP: begin
`ifdef TONE_GAP_EN
            if (stop) state_next = IDLE;
            else if (dur == CNT_W'(GAP_CYCLES) - CNT_W'(1))
               state_next = DONE;
`else
            state_next = IDLE;
`endif
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         oct_q  <= '0;
         note_q <= '0;
         len_q  <= '0;
      end else if (accept) begin
         oct_q  <= octave;
         note_q <= note;
         len_q  <= length;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                            dur <= '0;
      else if (state_next != state)       dur <= '0;
      else if (state == PLAY || state == GAP) dur <= dur + CNT_W'(1);
      else                                dur <= '0;
   end

   // Gating on the next state clears the buzzer on the edge that leaves PLAY.
   assign tone_en = (state == PLAY) && (state_next == PLAY) && is_tone(note_q);

   tone_divider #(.W(DIV_W)) u_div (
      .clk         (clk),
      .rst         (rst),
      .enable      (tone_en),
      .half_period (DIV_W'(note_half_period(oct_q, note_q))),
      .wave        (buzzer)
   );

   assign busy = (state != IDLE);
   assign done = (state == DONE);

endmodule
